tpx3_frame_seq: RTL and testbench
=================================

Name: tpx3_frame_seq

Overview:
Acquisition sequencer for the Timepix3 readout path. It generates the T0_Sync, Shutter and ExtTPulse control strobes from a programmed frame recipe: an optional T0 pulse, a pre-delay, then N shutter windows separated by gaps, with optional test pulses inside each window. It sits between the GPIO/register layer, which supplies configuration, START and STOP, and the chip control outputs. It also emits a per-frame strobe for the shutter timestamp unit.

Parameters:
CNT_WIDTH, 32, width of the length, gap and frame counters
TP_WIDTH_W, 16, width of the test-pulse width/period/count fields
T0_LEN, 4, T0_SYNC high time in clocks (≥1)

Ports:
BUS_CLK  in  1  sole clock; all logic on the rising edge
BUS_RST_N  in  1  asynchronous active-low reset
START  in  1  level; sampled only in IDLE
STOP  in  1  abort request; any state
EN_T0  in  1  issue a T0_SYNC pulse before the first frame
DELAY_LEN  in  CNT_WIDTH  clocks between T0 (or start) and the first shutter
SHUTTER_LEN  in  CNT_WIDTH  shutter-open clocks per frame
GAP_LEN  in  CNT_WIDTH  shutter-closed clocks between frames
FRAMES  in  CNT_WIDTH  frame count; 0 = run until STOP
TP_NUM  in  TP_WIDTH_W  test pulses per frame; 0 = none
TP_OFFSET  in  TP_WIDTH_W  open-window clock of the first pulse rising edge
TP_PERIOD  in  TP_WIDTH_W  rising-edge spacing
TP_WIDTH  in  TP_WIDTH_W  pulse high time
SHUTTER  out  1  chip shutter
T0_SYNC  out  1  chip T0 sync
EXT_TPULSE  out  1  chip external test pulse
FRAME_START  out  1  one-cycle strobe coincident with the SHUTTER rising edge
BUSY  out  1  high outside IDLE
DONE  out  1  one-cycle strobe on return to IDLE
FRAME_CNT  out  CNT_WIDTH  completed frames since the last START; wraps

Behaviour:
- Reset: state IDLE. All outputs are 0, counters are 0 and latched configuration is 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Configuration is latched on the START-accept cycle. Later input changes have no effect until the next run.
- States: IDLE, T0, DELAY, OPEN, GAP.
- IDLE: when START=1 and STOP=0 at cycle n, latch the config, clear FRAME_CNT and go to T0 if EN_T0, else DELAY. BUSY=1 from n+1.
- T0: T0_SYNC=1 for exactly T0_LEN cycles, starting at n+1, then DELAY.
- DELAY: lasts DELAY_LEN cycles. DELAY_LEN=0 means no DELAY cycle; OPEN follows immediately.
- OPEN: SHUTTER=1 for exactly max(SHUTTER_LEN,1) cycles. FRAME_START=1 in the first OPEN cycle.
- End of OPEN: FRAME_CNT increments on the last OPEN cycle, visible the next cycle.
  - If FRAMES≠0 and the incremented count equals FRAMES, go to IDLE.
  - Otherwise go to GAP.
- GAP: SHUTTER=0 for max(GAP_LEN,1) cycles (at least one low cycle between frames), then OPEN.
- Test pulses: an in-window counter k starts at 0 in the first OPEN cycle.
  - Pulse i (0 ≤ i < TP_NUM) rises at k = TP_OFFSET + i·TP_PERIOD.
  - High time is min(TP_WIDTH, TP_PERIOD−1), with a minimum of 1.
  - Pulses that would rise at or after the window end are not issued.
  - EXT_TPULSE is forced to 0 on the first cycle SHUTTER=0.
  - TP_PERIOD=0 is treated as 1 and allows only pulse 0.
- STOP=1 in any non-IDLE state: next cycle the state is IDLE and SHUTTER/T0_SYNC/EXT_TPULSE are 0. DONE=1 that cycle, and FRAME_CNT holds its value (a partial frame is not counted).
- STOP=1 has priority over START in IDLE: START is not accepted.
- DONE pulses on every return to IDLE from a run, including aborts.
- START held high after DONE starts a new run on the first IDLE cycle. DONE and the new START-accept coincide.
- An asynchronous reset mid-run drops all outputs immediately. DONE is not generated.

Decomposition:
- Shared package tpx3_seq_pkg holds the state encoding (IDLE=0, T0=1, DELAY=2, OPEN=3, GAP=4) and the default widths.
- One sub-module, tpx3_tpulse_gen: it takes the window-open signal and the TP_* fields and produces EXT_TPULSE. It keeps its own offset/period/width/count counters and clears on window close.

Test Plan:
1. EN_T0=1, DELAY=3, SHUTTER=5, GAP=2, FRAMES=2, START at cycle 0:
   - T0_SYNC high cycles 1–4.
   - SHUTTER high 8–12 and 15–19.
   - FRAME_START at 8 and 15.
   - DONE at 20; FRAME_CNT=2.
2. EN_T0=0, DELAY=0, SHUTTER=0, GAP=0, FRAMES=3:
   - SHUTTER high cycles 1, 3, 5; low 2, 4.
   - DONE at 6.
3. SHUTTER=20, TP_NUM=3, OFFSET=2, PERIOD=6, WIDTH=10:
   - EXT_TPULSE high at window clocks 2–6, 8–12, 14–18 (width clamped to 5).
4. SHUTTER=10, TP_NUM=4, OFFSET=1, PERIOD=4, WIDTH=3:
   - Pulses at window clocks 1–3, 5–7, 9; the fourth pulse (clock 13) is not issued.
   - The third pulse is cut at window end.
5. FRAMES=0, STOP asserted mid-OPEN of frame 5:
   - SHUTTER=0 and DONE=1 on the next cycle.
   - FRAME_CNT=4.
   - START and STOP held high together in IDLE: no run starts.
6. BUS_RST_N low during GAP: all outputs 0 asynchronously; DONE=0; BUSY=0 after release.

Source files
------------

// File: rtl/tpx3_seq_pkg.sv
// Shared definitions for the Timepix3 acquisition sequencer: state encoding and default widths.
package tpx3_seq_pkg;

  localparam int unsigned CNT_WIDTH_DEF = 32;
  localparam int unsigned TP_WIDTH_DEF  = 16;
  localparam int unsigned T0_LEN_DEF    = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_T0    = 3'd1,
    ST_DELAY = 3'd2,
    ST_OPEN  = 3'd3,
    ST_GAP   = 3'd4
  } seq_state_e;

endpackage

// File: rtl/tpx3_tpulse_gen.sv
// Test-pulse generator: produces EXT_TPULSE inside each shutter window from offset/period/width/count.
// Driven by the next-cycle window flag so that its registered output lines up with SHUTTER.
module tpx3_tpulse_gen
  import tpx3_seq_pkg::*;
#(
  parameter int unsigned TP_WIDTH_W = TP_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  win_open_nxt,
  input  logic [TP_WIDTH_W-1:0] tp_num,
  input  logic [TP_WIDTH_W-1:0] tp_offset,
  input  logic [TP_WIDTH_W-1:0] tp_period,
  input  logic [TP_WIDTH_W-1:0] tp_width,
  output logic                  ext_tpulse
);

  localparam logic [TP_WIDTH_W-1:0] ONE = TP_WIDTH_W'(1);

  logic                  win_q, win_d;
  logic                  started_q, started_d;
  logic [TP_WIDTH_W-1:0] off_q, off_d;
  logic [TP_WIDTH_W-1:0] per_q, per_d;
  logic [TP_WIDTH_W-1:0] wid_q, wid_d;
  logic [TP_WIDTH_W-1:0] num_q, num_d;
  logic                  ext_q, ext_d;

  logic [TP_WIDTH_W-1:0] per_eff_c, wid_cap_c, wid_eff_c, num_lim_c;
  logic                  new_win_c, rise_c;

  // Period 0 acts as 1 but allows only the first pulse; width is kept below the period.
  assign per_eff_c = (tp_period == '0) ? ONE : tp_period;
  assign wid_cap_c = per_eff_c - ONE;
  assign wid_eff_c = (wid_cap_c == '0 || tp_width == '0) ? ONE :
                     ((tp_width < wid_cap_c) ? tp_width : wid_cap_c);
  assign num_lim_c = (tp_period == '0 && tp_num != '0) ? ONE : tp_num;
  assign new_win_c = win_open_nxt && !win_q;

  always_comb begin
    win_d     = win_open_nxt;
    started_d = started_q;
    off_d     = off_q;
    per_d     = per_q;
    wid_d     = wid_q;
    num_d     = num_q;
    rise_c    = 1'b0;
    ext_d     = 1'b0;
    if (!win_open_nxt) begin
      started_d = 1'b0;
      off_d     = '0;
      per_d     = '0;
      wid_d     = '0;
      num_d     = '0;
    end else begin
      if (new_win_c) begin
        started_d = 1'b0;
        off_d     = tp_offset;
        per_d     = '0;
        wid_d     = '0;
        num_d     = '0;
      end else if (!started_q && off_q != '0) begin
        off_d = off_q - ONE;
      end else if (started_q) begin
        per_d = per_q + ONE;
      end
      if (num_d < num_lim_c) begin
        if (!started_d) rise_c = (off_d == '0);
        else            rise_c = (per_d == per_eff_c);
      end
      // A rise reloads the width counter; otherwise the current pulse drains.
      if (rise_c) begin
        started_d = 1'b1;
        per_d     = '0;
        wid_d     = wid_eff_c;
        num_d     = num_d + ONE;
      end else if (wid_d != '0) begin
        wid_d = wid_d - ONE;
      end
      ext_d = (wid_d != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q     <= 1'b0;
      started_q <= 1'b0;
      off_q     <= '0;
      per_q     <= '0;
      wid_q     <= '0;
      num_q     <= '0;
      ext_q     <= 1'b0;
    end else begin
      win_q     <= win_d;
      started_q <= started_d;
      off_q     <= off_d;
      per_q     <= per_d;
      wid_q     <= wid_d;
      num_q     <= num_d;
      ext_q     <= ext_d;
    end
  end

  assign ext_tpulse = ext_q;

endmodule

// File: rtl/tpx3_frame_seq.sv
// Timepix3 acquisition sequencer: T0 pulse, pre-delay, then N shutter windows separated by gaps.
// Every output is a flop loaded from the next-state decode.
module tpx3_frame_seq
  import tpx3_seq_pkg::*;
#(
  parameter int unsigned CNT_WIDTH  = CNT_WIDTH_DEF,
  parameter int unsigned TP_WIDTH_W = TP_WIDTH_DEF,
  parameter int unsigned T0_LEN     = T0_LEN_DEF
) (
  input  logic                  BUS_CLK,
  input  logic                  BUS_RST_N,
  input  logic                  START,
  input  logic                  STOP,
  input  logic                  EN_T0,
  input  logic [CNT_WIDTH-1:0]  DELAY_LEN,
  input  logic [CNT_WIDTH-1:0]  SHUTTER_LEN,
  input  logic [CNT_WIDTH-1:0]  GAP_LEN,
  input  logic [CNT_WIDTH-1:0]  FRAMES,
  input  logic [TP_WIDTH_W-1:0] TP_NUM,
  input  logic [TP_WIDTH_W-1:0] TP_OFFSET,
  input  logic [TP_WIDTH_W-1:0] TP_PERIOD,
  input  logic [TP_WIDTH_W-1:0] TP_WIDTH,
  output logic                  SHUTTER,
  output logic                  T0_SYNC,
  output logic                  EXT_TPULSE,
  output logic                  FRAME_START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic [CNT_WIDTH-1:0]  FRAME_CNT
);

  localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] T0_LAST = CNT_WIDTH'(T0_LEN - 1);

  seq_state_e state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0]  delay_len_q, delay_len_d;
  logic [CNT_WIDTH-1:0]  shutter_len_q, shutter_len_d;
  logic [CNT_WIDTH-1:0]  gap_len_q, gap_len_d;
  logic [CNT_WIDTH-1:0]  frames_q, frames_d;
  logic [TP_WIDTH_W-1:0] tp_num_q, tp_num_d;
  logic [TP_WIDTH_W-1:0] tp_offset_q, tp_offset_d;
  logic [TP_WIDTH_W-1:0] tp_period_q, tp_period_d;
  logic [TP_WIDTH_W-1:0] tp_width_q, tp_width_d;
  logic shutter_q, shutter_d;
  logic t0_sync_q, t0_sync_d;
  logic frame_start_q, frame_start_d;
  logic busy_q, busy_d;
  logic done_q, done_d;

  logic                 t0_last_c, delay_last_c, open_last_c, gap_last_c;
  logic [CNT_WIDTH-1:0] frame_inc_c;

  // Zero-length OPEN/GAP still last one cycle.
  assign t0_last_c    = (cnt_q == T0_LAST);
  assign delay_last_c = (cnt_q == delay_len_q - ONE);
  assign open_last_c  = (shutter_len_q == '0) || (cnt_q == shutter_len_q - ONE);
  assign gap_last_c   = (gap_len_q == '0) || (cnt_q == gap_len_q - ONE);
  assign frame_inc_c  = frame_cnt_q + ONE;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    frame_cnt_d   = frame_cnt_q;
    delay_len_d   = delay_len_q;
    shutter_len_d = shutter_len_q;
    gap_len_d     = gap_len_q;
    frames_d      = frames_q;
    tp_num_d      = tp_num_q;
    tp_offset_d   = tp_offset_q;
    tp_period_d   = tp_period_q;
    tp_width_d    = tp_width_q;
    done_d        = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (START && !STOP) begin
          delay_len_d   = DELAY_LEN;
          shutter_len_d = SHUTTER_LEN;
          gap_len_d     = GAP_LEN;
          frames_d      = FRAMES;
          tp_num_d      = TP_NUM;
          tp_offset_d   = TP_OFFSET;
          tp_period_d   = TP_PERIOD;
          tp_width_d    = TP_WIDTH;
          frame_cnt_d   = '0;
          cnt_d         = '0;
          if (EN_T0)                state_d = ST_T0;
          else if (DELAY_LEN != '0) state_d = ST_DELAY;
          else                      state_d = ST_OPEN;
        end
      end
      ST_T0: begin
        if (t0_last_c) begin
          cnt_d   = '0;
          state_d = (delay_len_q != '0) ? ST_DELAY : ST_OPEN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_DELAY: begin
        if (delay_last_c) begin
          cnt_d   = '0;
          state_d = ST_OPEN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_OPEN: begin
        if (open_last_c) begin
          cnt_d       = '0;
          frame_cnt_d = frame_inc_c;
          if (frames_q != '0 && frame_inc_c == frames_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      ST_GAP: begin
        if (gap_last_c) begin
          cnt_d   = '0;
          state_d = ST_OPEN;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    // Abort: a partially exposed frame is not counted.
    if (state_q != ST_IDLE && STOP) begin
      state_d     = ST_IDLE;
      cnt_d       = '0;
      frame_cnt_d = frame_cnt_q;
      done_d      = 1'b1;
    end

    shutter_d     = (state_d == ST_OPEN);
    t0_sync_d     = (state_d == ST_T0);
    frame_start_d = (state_d == ST_OPEN) && (state_q != ST_OPEN);
    busy_d        = (state_d != ST_IDLE);
  end

  always_ff @(posedge BUS_CLK or negedge BUS_RST_N) begin
    if (!BUS_RST_N) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      frame_cnt_q   <= '0;
      delay_len_q   <= '0;
      shutter_len_q <= '0;
      gap_len_q     <= '0;
      frames_q      <= '0;
      tp_num_q      <= '0;
      tp_offset_q   <= '0;
      tp_period_q   <= '0;
      tp_width_q    <= '0;
      shutter_q     <= 1'b0;
      t0_sync_q     <= 1'b0;
      frame_start_q <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      delay_len_q   <= delay_len_d;
      shutter_len_q <= shutter_len_d;
      gap_len_q     <= gap_len_d;
      frames_q      <= frames_d;
      tp_num_q      <= tp_num_d;
      tp_offset_q   <= tp_offset_d;
      tp_period_q   <= tp_period_d;
      tp_width_q    <= tp_width_d;
      shutter_q     <= shutter_d;
      t0_sync_q     <= t0_sync_d;
      frame_start_q <= frame_start_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  // Fed with next-cycle config so a run starting straight into OPEN sees the new TP fields.
  tpx3_tpulse_gen #(
    .TP_WIDTH_W (TP_WIDTH_W)
  ) u_tpulse (
    .clk          (BUS_CLK),
    .rst_n        (BUS_RST_N),
    .win_open_nxt (shutter_d),
    .tp_num       (tp_num_d),
    .tp_offset    (tp_offset_d),
    .tp_period    (tp_period_d),
    .tp_width     (tp_width_d),
    .ext_tpulse   (EXT_TPULSE)
  );

  assign SHUTTER     = shutter_q;
  assign T0_SYNC     = t0_sync_q;
  assign FRAME_START = frame_start_q;
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign FRAME_CNT   = frame_cnt_q;

endmodule

// File: tb/tb_tpx3_frame_seq.sv
// Bench for tpx3_frame_seq: per-cycle outputs compared with a timeline built from the frame recipe.
module tb_tpx3_frame_seq;

  localparam int unsigned CW  = 32;
  localparam int unsigned TW  = 16;
  localparam int unsigned T0L = 4;

  logic          BUS_CLK = 1'b0;
  logic          BUS_RST_N;
  logic          START, STOP, EN_T0;
  logic [CW-1:0] DELAY_LEN, SHUTTER_LEN, GAP_LEN, FRAMES;
  logic [TW-1:0] TP_NUM, TP_OFFSET, TP_PERIOD, TP_WIDTH;
  logic          SHUTTER, T0_SYNC, EXT_TPULSE, FRAME_START, BUSY, DONE;
  logic [CW-1:0] FRAME_CNT;

  typedef struct packed {
    logic          sh;
    logic          t0;
    logic          tp;
    logic          fs;
    logic          busy;
    logic          done;
    logic [CW-1:0] fc;
  } obs_t;

  typedef struct {
    int en_t0, delay, sh, gap, frames, num, off, per, wid;
  } cfg_t;

  obs_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  tpx3_frame_seq #(.CNT_WIDTH(CW), .TP_WIDTH_W(TW), .T0_LEN(T0L)) dut (
    .BUS_CLK(BUS_CLK), .BUS_RST_N(BUS_RST_N), .START(START), .STOP(STOP), .EN_T0(EN_T0),
    .DELAY_LEN(DELAY_LEN), .SHUTTER_LEN(SHUTTER_LEN), .GAP_LEN(GAP_LEN), .FRAMES(FRAMES),
    .TP_NUM(TP_NUM), .TP_OFFSET(TP_OFFSET), .TP_PERIOD(TP_PERIOD), .TP_WIDTH(TP_WIDTH),
    .SHUTTER(SHUTTER), .T0_SYNC(T0_SYNC), .EXT_TPULSE(EXT_TPULSE), .FRAME_START(FRAME_START),
    .BUSY(BUSY), .DONE(DONE), .FRAME_CNT(FRAME_CNT)
  );

  always #5 BUS_CLK = ~BUS_CLK;

  function automatic obs_t cur();
    obs_t o;
    o.sh = SHUTTER; o.t0 = T0_SYNC; o.tp = EXT_TPULSE; o.fs = FRAME_START;
    o.busy = BUSY; o.done = DONE; o.fc = FRAME_CNT;
    return o;
  endfunction

  task automatic check(input string tag, input obs_t e);
    obs_t o;
    o = cur();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s observed sh/t0/tp/fs/busy/done/fc=%b%b%b%b%b%b/%0d expected=%b%b%b%b%b%b/%0d",
             tag, o.sh, o.t0, o.tp, o.fs, o.busy, o.done, o.fc,
             e.sh, e.t0, e.tp, e.fs, e.busy, e.done, e.fc);
    end
  endtask

  // Is the test pulse high at window clock k of a w-clock window?
  function automatic logic tp_ref(input int k, input int w, input cfg_t c);
    int pe, lim, we, r;
    pe  = (c.per == 0) ? 1 : c.per;
    lim = (c.per == 0 && c.num != 0) ? 1 : c.num;
    we  = (c.wid < pe - 1) ? c.wid : pe - 1;
    if (we < 1) we = 1;
    for (int i = 0; i < lim; i++) begin
      r = c.off + i * pe;
      if (r < w && k >= r && k < r + we) return 1'b1;
    end
    return 1'b0;
  endfunction

  // Expected outputs for cycles 1.. after the START-accept cycle, ending with one idle cycle.
  task automatic build(input cfg_t c);
    obs_t e;
    int   w, g;
    exp_q.delete();
    e = '0;
    e.busy = 1'b1;
    if (c.en_t0 != 0) begin
      e.t0 = 1'b1;
      repeat (T0L) exp_q.push_back(e);
      e.t0 = 1'b0;
    end
    repeat (c.delay) exp_q.push_back(e);
    w = (c.sh < 1) ? 1 : c.sh;
    g = (c.gap < 1) ? 1 : c.gap;
    for (int f = 1; f <= c.frames; f++) begin
      for (int k = 0; k < w; k++) begin
        e.sh = 1'b1; e.fs = (k == 0); e.tp = tp_ref(k, w, c); e.fc = CW'(f - 1);
        exp_q.push_back(e);
      end
      e.sh = 1'b0; e.fs = 1'b0; e.tp = 1'b0; e.fc = CW'(f);
      if (f == c.frames) begin
        e.busy = 1'b0; e.done = 1'b1;
        exp_q.push_back(e);
        e.done = 1'b0;
        exp_q.push_back(e);
      end else begin
        repeat (g) exp_q.push_back(e);
      end
    end
  endtask

  // stop_at / rst_at: timeline index after which STOP or an async reset is applied (-1 = none).
  task automatic run(input string tag, input cfg_t c, input int frames_dut,
                     input int stop_at, input int rst_at);
    obs_t z;
    int   last;
    build(c);
    @(negedge BUS_CLK);
    EN_T0 = (c.en_t0 != 0); DELAY_LEN = CW'(c.delay); SHUTTER_LEN = CW'(c.sh);
    GAP_LEN = CW'(c.gap); FRAMES = CW'(frames_dut); TP_NUM = TW'(c.num);
    TP_OFFSET = TW'(c.off); TP_PERIOD = TW'(c.per); TP_WIDTH = TW'(c.wid);
    START = 1'b1;
    @(posedge BUS_CLK); #1;
    START = 1'b0;
    EN_T0 = 1'($urandom); DELAY_LEN = $urandom; SHUTTER_LEN = $urandom;
    GAP_LEN = $urandom; FRAMES = $urandom; TP_NUM = TW'($urandom);
    TP_OFFSET = TW'($urandom); TP_PERIOD = TW'($urandom); TP_WIDTH = TW'($urandom);
    last = exp_q.size() - 1;
    if (stop_at >= 0) last = stop_at;
    if (rst_at >= 0) last = rst_at;
    for (int j = 0; j <= last; j++) begin
      if (j > 0) begin @(posedge BUS_CLK); #1; end
      check($sformatf("%s[%0d]", tag, j), exp_q[j]);
    end
    z = '0;
    if (stop_at >= 0) begin
      STOP = 1'b1;
      @(posedge BUS_CLK); #1;
      z.done = 1'b1; z.fc = exp_q[stop_at].fc;
      check({tag, "_stop"}, z);
      z.done = 1'b0;
      START = 1'b1;
      for (int j = 0; j < 3; j++) begin
        @(posedge BUS_CLK); #1;
        check($sformatf("%s_startstop[%0d]", tag, j), z);
      end
      START = 1'b0; STOP = 1'b0;
    end
    if (rst_at >= 0) begin
      #2 BUS_RST_N = 1'b0;
      #1 check({tag, "_rst_async"}, z);
      @(negedge BUS_CLK); BUS_RST_N = 1'b1;
      for (int j = 0; j < 2; j++) begin
        @(posedge BUS_CLK); #1;
        check($sformatf("%s_rst_after[%0d]", tag, j), z);
      end
    end
  endtask

  function automatic int find_idx(input int nth_fs, input int plus);
    int n;
    n = 0;
    foreach (exp_q[j]) begin
      if (exp_q[j].fs) n++;
      if (n == nth_fs) return j + plus;
    end
    return -1;
  endfunction

  initial begin
    cfg_t c;
    obs_t z;
    int   idx;
    BUS_RST_N = 1'b0; START = 1'b0; STOP = 1'b0; EN_T0 = 1'b0;
    DELAY_LEN = '0; SHUTTER_LEN = '0; GAP_LEN = '0; FRAMES = '0;
    TP_NUM = '0; TP_OFFSET = '0; TP_PERIOD = '0; TP_WIDTH = '0;
    z = '0;
    #1 check("reset", z);
    repeat (2) @(posedge BUS_CLK);
    @(negedge BUS_CLK); BUS_RST_N = 1'b1;
    @(posedge BUS_CLK); #1 check("idle_after_reset", z);

    c = '{en_t0:1, delay:3, sh:5, gap:2, frames:2, num:0, off:0, per:0, wid:0};
    run("t0_delay_2frames", c, c.frames, -1, -1);
    c = '{en_t0:0, delay:0, sh:0, gap:0, frames:3, num:0, off:0, per:0, wid:0};
    run("zero_lengths", c, c.frames, -1, -1);
    c = '{en_t0:0, delay:1, sh:20, gap:1, frames:1, num:3, off:2, per:6, wid:10};
    run("tp_width_clamp", c, c.frames, -1, -1);
    c = '{en_t0:0, delay:0, sh:10, gap:1, frames:1, num:4, off:1, per:4, wid:3};
    run("tp_window_cut", c, c.frames, -1, -1);
    c = '{en_t0:0, delay:0, sh:4, gap:2, frames:2, num:3, off:1, per:0, wid:3};
    run("tp_period0", c, c.frames, -1, -1);

    // Free-running run aborted two clocks into frame 5.
    c = '{en_t0:0, delay:2, sh:6, gap:2, frames:6, num:1, off:0, per:3, wid:1};
    build(c);
    idx = find_idx(5, 2);
    run("stop_mid_open", c, 0, idx, -1);

    // Async reset during the first gap.
    c = '{en_t0:1, delay:1, sh:3, gap:4, frames:3, num:1, off:1, per:2, wid:1};
    build(c);
    idx = find_idx(1, 4);
    run("rst_in_gap", c, c.frames, -1, idx);

    for (int r = 0; r < 10; r++) begin
      c.en_t0  = int'($urandom_range(0, 1));
      c.delay  = int'($urandom_range(0, 4));
      c.sh     = int'($urandom_range(0, 12));
      c.gap    = int'($urandom_range(0, 3));
      c.frames = int'($urandom_range(1, 3));
      c.num    = int'($urandom_range(0, 4));
      c.off    = int'($urandom_range(0, 8));
      c.per    = int'($urandom_range(0, 6));
      c.wid    = int'($urandom_range(0, 6));
      run($sformatf("rand%0d", r), c, c.frames, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
